// File: rtl/extend_pkg.sv
// Shared types and helpers for the sequential immediate extender.
// MAX_XLEN bounds the datapath width that ror_xlen can handle.
package extend_pkg;

    localparam int unsigned REM_W    = 5;
    localparam int unsigned MAX_XLEN = 128;

    typedef enum logic [2:0] {
        IMM_ROT8   = 3'b000,
        IMM_Z12    = 3'b001,
        IMM_BR24   = 3'b010,
        IMM_HSPLIT = 3'b011,
        IMM_MOVW   = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_e;

    // Rotate right by amt within the low xlen bits of v; amt must be < xlen.
    function automatic logic [MAX_XLEN-1:0] ror_xlen(
        input logic [MAX_XLEN-1:0] v,
        input int unsigned         amt,
        input int unsigned         xlen
    );
        logic [MAX_XLEN-1:0] mask;
        logic [MAX_XLEN-1:0] x;
        mask = {MAX_XLEN{1'b1}} >> (MAX_XLEN - xlen);
        x    = v & mask;
        return ((x >> amt) | (x << (xlen - amt))) & mask;
    endfunction

endpackage

// File: rtl/extend_rot_step.sv
// One iteration of the rotated-immediate path: rotate right by
// min(rem, ROT_STEP) and return the remaining rotate amount.
module extend_rot_step
    import extend_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ROT_STEP = 8
) (
    input  logic [XLEN-1:0]  value,
    input  logic [REM_W-1:0] rem,
    output logic [XLEN-1:0]  next_value,
    output logic [REM_W-1:0] next_rem
);

    localparam logic [REM_W-1:0] STEP = REM_W'(ROT_STEP);

    logic [REM_W-1:0] amt;

    always_comb begin
        amt        = (rem < STEP) ? rem : STEP;
        next_value = XLEN'(ror_xlen(MAX_XLEN'(value), 32'(amt), XLEN));
        next_rem   = rem - amt;
    end

endmodule

// File: rtl/extend_seq.sv
// Multi-cycle immediate extender with valid/ready on both sides; rotated
// imm8 values are produced iteratively by extend_rot_step.
module extend_seq
    import extend_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ROT_STEP = 8,
    parameter int unsigned SRC_W    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [23:0]      Instr,
    input  logic [SRC_W-1:0] ImmSrc,
    input  logic             CarryIn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [XLEN-1:0]  ExtImm,
    output logic             CarryOut,
    output logic             ImmErr,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e state;
    state_e next_state;

    logic [XLEN-1:0]  value_q;
    logic [REM_W-1:0] rem_q;
    logic             carry_q;
    logic             err_q;

    logic [XLEN-1:0]  dec_value;
    logic [REM_W-1:0] dec_rem;
    logic             dec_err;
    logic [XLEN-1:0]  step_value;
    logic [REM_W-1:0] step_rem;
    logic             accept;

    assign accept = in_ready && in_valid && !flush;

    extend_rot_step #(
        .XLEN     (XLEN),
        .ROT_STEP (ROT_STEP)
    ) u_rot_step (
        .value      (value_q),
        .rem        (rem_q),
        .next_value (step_value),
        .next_rem   (step_rem)
    );

    // dec_rem is only nonzero for a rotated imm8 that actually needs rotating.
    always_comb begin
        dec_value = '0;
        dec_rem   = '0;
        dec_err   = 1'b0;
        case (ImmSrc)
            SRC_W'(IMM_ROT8): begin
                dec_value = XLEN'(Instr[7:0]);
                dec_rem   = REM_W'({Instr[11:8], 1'b0});
            end
            SRC_W'(IMM_Z12):    dec_value = XLEN'(Instr[11:0]);
            SRC_W'(IMM_BR24):   dec_value = {{(XLEN-26){Instr[23]}}, Instr, 2'b00};
            SRC_W'(IMM_HSPLIT): dec_value = XLEN'({Instr[11:8], Instr[3:0]});
            SRC_W'(IMM_MOVW):   dec_value = XLEN'({Instr[19:16], Instr[11:0]});
            default:            dec_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (dec_rem != '0) ? ROT : DONE;
            ROT: begin
                if (flush)                next_state = IDLE;
                else if (step_rem == '0)  next_state = DONE;
            end
            DONE: if (flush || out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        value_q <= dec_value;
                        rem_q   <= dec_rem;
                        carry_q <= CarryIn;
                        err_q   <= dec_err;
                    end
                end
                ROT: begin
                    if (flush) begin
                        value_q <= '0;
                        rem_q   <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b0;
                    end else begin
                        value_q <= step_value;
                        rem_q   <= step_rem;
                        if (step_rem == '0) carry_q <= step_value[XLEN-1];
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        value_q <= '0;
                        rem_q   <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    value_q <= '0;
                    rem_q   <= '0;
                    carry_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is gated by reset_n so it reads 0 while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && reset_n;
        out_valid = (state == DONE);
        ExtImm    = value_q;
        CarryOut  = carry_q;
        ImmErr    = err_q;
    end

endmodule

// File: tb/tb_extend_seq.sv
// Self-checking bench for extend_seq: directed cases plus randomized requests
// checked against an arithmetic reference model.
module tb_extend_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] Instr = '0;
    logic [2:0]  ImmSrc = '0;
    logic        CarryIn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_ready2 = 1'b0;
    logic        in_ready, in_ready2;
    logic [31:0] ext_imm, ext_imm2;
    logic        carry_out, carry_out2;
    logic        imm_err, imm_err2;
    logic        out_valid, out_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    extend_seq #(.XLEN(32), .ROT_STEP(8), .SRC_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ImmSrc(ImmSrc),
        .CarryIn(CarryIn), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ExtImm(ext_imm), .CarryOut(carry_out),
        .ImmErr(imm_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    extend_seq #(.XLEN(32), .ROT_STEP(2), .SRC_W(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ImmSrc(ImmSrc),
        .CarryIn(CarryIn), .in_valid(in_valid2), .in_ready(in_ready2),
        .flush(flush), .ExtImm(ext_imm2), .CarryOut(carry_out2),
        .ImmErr(imm_err2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    // Reference: rotation via a doubled word, sign extension via subtraction.
    function automatic void model(input logic [23:0] instr, input logic [2:0] src,
                                  input logic cin, input int step,
                                  output logic [31:0] val, output logic c,
                                  output logic e, output int lat);
        logic [63:0] dbl;
        int amt;
        int s;
        val = '0; c = cin; e = 1'b0; lat = 1;
        case (src)
            3'd0: begin
                amt = 2 * int'(instr[11:8]);
                dbl = {24'd0, instr[7:0], 24'd0, instr[7:0]};
                val = dbl[31:0];
                if (amt != 0) begin
                    dbl = dbl >> amt;
                    val = dbl[31:0];
                    c   = val[31];
                    lat = 1 + (amt + step - 1) / step;
                end
            end
            3'd1: val = 32'(instr[11:0]);
            3'd2: begin
                s = int'({instr, 2'b00});
                if (instr[23]) s = s - (1 << 26);
                val = s;
            end
            3'd3: val = 32'(int'(instr[11:8]) * 16 + int'(instr[3:0]));
            3'd4: val = 32'(int'(instr[19:16]) * 4096 + int'(instr[11:0]));
            default: e = 1'b1;
        endcase
    endfunction

    // Present one request in IDLE, then wait (bounded) for out_valid.
    task automatic do_req(input logic [23:0] instr, input logic [2:0] src,
                          input logic cin, output int lat);
        @(negedge clk);
        Instr = instr; ImmSrc = src; CarryIn = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        Instr = 24'($urandom); ImmSrc = 3'($urandom); CarryIn = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ext_imm, carry_out, imm_err, out_valid, in_ready} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {ext_imm, carry_out, imm_err, out_valid, in_ready});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [23:0] ti [6] = '{24'h0004FF, 24'h000F01, 24'hFFFFFE, 24'h0A0BCD, 24'h00050C, 24'h000123};
        logic [2:0]  ts [6] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd3, 3'd7};
        logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] tv [6] = '{32'hFF000000, 32'h4, 32'hFFFFFFF8, 32'h0000ABCD, 32'h5C, 32'h0};
        logic        tco[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        te [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          tl [6] = '{2, 5, 1, 1, 1, 1};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_req(ti[i], ts[i], tc[i], lat);
            checks++;
            if (lat !== tl[i] || ext_imm !== tv[i] || carry_out !== tco[i] || imm_err !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d got lat=%0d imm=%h c=%b e=%b want lat=%0d imm=%h c=%b e=%b",
                         i, lat, ext_imm, carry_out, imm_err, tl[i], tv[i], tco[i], te[i]);
            end
            consume();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_consume_%0d got v=%b r=%b want v=0 r=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_step2();
        int lat;
        @(negedge clk);
        Instr = 24'h000F01; ImmSrc = 3'd0; CarryIn = 1'b1; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0; Instr = 24'($urandom); ImmSrc = 3'($urandom);
        lat = 1;
        while (!out_valid2 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 16 || ext_imm2 !== 32'h4 || carry_out2 !== 1'b0 || imm_err2 !== 1'b0) begin
            errors++;
            $display("FAIL step2_rot30 got lat=%0d imm=%h c=%b e=%b want lat=16 imm=00000004 c=0 e=0",
                     lat, ext_imm2, carry_out2, imm_err2);
        end
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL step2_consume got v=%b r=%b want v=0 r=1", out_valid2, in_ready2);
        end
    endtask

    task automatic test_random();
        logic [23:0] ri;
        logic [2:0]  rs;
        logic        rc, mc, me;
        logic [31:0] mv;
        int lat, mlat;
        for (int n = 0; n < 40; n++) begin
            ri = 24'($urandom);
            rs = 3'($urandom_range(0, 7));
            if (n % 3 == 0) rs = 3'd0;
            rc = 1'($urandom);
            model(ri, rs, rc, 8, mv, mc, me, mlat);
            do_req(ri, rs, rc, lat);
            checks++;
            if (lat !== mlat || ext_imm !== mv || carry_out !== mc || imm_err !== me) begin
                errors++;
                $display("FAIL random_%0d instr=%h src=%0d got lat=%0d imm=%h c=%b e=%b want lat=%0d imm=%h c=%b e=%b",
                         n, ri, rs, lat, ext_imm, carry_out, imm_err, mlat, mv, mc, me);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mv;
        logic        mc, me;
        int lat, mlat;
        do_req(24'h000ABC, 3'd1, 1'b1, lat);
        Instr = 24'h0A0BCD; ImmSrc = 3'd4; CarryIn = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ext_imm !== 32'h00000ABC || carry_out !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got v=%b r=%b imm=%h c=%b want v=1 r=0 imm=00000abc c=1",
                         k, out_valid, in_ready, ext_imm, carry_out);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_gap got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        model(24'h0A0BCD, 3'd4, 1'b0, 8, mv, mc, me, mlat);
        checks++;
        if (out_valid !== 1'b1 || ext_imm !== mv || carry_out !== mc || imm_err !== me) begin
            errors++;
            $display("FAIL second_result got v=%b imm=%h c=%b want v=1 imm=%h c=%b", out_valid, ext_imm, carry_out, mv, mc);
        end
        consume();
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        @(negedge clk);
        Instr = 24'h000F01; ImmSrc = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ext_imm !== 32'h0) begin
            errors++;
            $display("FAIL flush_rot got r=%b v=%b imm=%h want r=1 v=0 imm=0", in_ready, out_valid, ext_imm);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_result got out_valid=%b want 0", seen);
        end
        // flush in IDLE blocks acceptance
        Instr = 24'h000123; ImmSrc = 3'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
        do_req(24'h000123, 3'd1, 1'b1, lat);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ext_imm !== 32'h0 || carry_out !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done got v=%b imm=%h c=%b r=%b want v=0 imm=0 c=0 r=1",
                     out_valid, ext_imm, carry_out, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        @(negedge clk);
        Instr = 24'h000F01; ImmSrc = 3'd0; CarryIn = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ext_imm, carry_out, imm_err, out_valid, in_ready} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", {ext_imm, carry_out, imm_err, out_valid, in_ready});
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_result got out_valid=%b want 0", seen);
        end
        do_req(24'h0004FF, 3'd0, 1'b0, lat);
        checks++;
        if (lat !== 2 || ext_imm !== 32'hFF000000 || carry_out !== 1'b1 || imm_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got lat=%0d imm=%h c=%b e=%b want lat=2 imm=ff000000 c=1 e=0",
                     lat, ext_imm, carry_out, imm_err);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_step2();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
